// File: rtl/ethpipe_csr_pkg.sv
// Shared word-index map and helpers for the ethpipe BAR0 register bank.
package ethpipe_csr_pkg;

    localparam logic [5:0] CSR_GCNT0      = 6'h02;
    localparam logic [5:0] CSR_GCNT1      = 6'h03;
    localparam logic [5:0] CSR_GCNT2      = 6'h04;
    localparam logic [5:0] CSR_GCNT3      = 6'h05;
    localparam logic [5:0] CSR_INTR_PEND  = 6'h08;
    localparam logic [5:0] CSR_INTR_MASK  = 6'h09;
    localparam logic [5:0] CSR_DMA_LEN0   = 6'h0A;
    localparam logic [5:0] CSR_DMA_LEN1   = 6'h0B;
    localparam logic [5:0] CSR_DMA_EN     = 6'h0C;
    localparam logic [5:0] CSR_PORT_BASE  = 6'h10;
    localparam int         CSR_PORT_STRIDE = 4;

    // The bus carries register byte 0 on the upper data lane and byte 1 on the lower one.
    function automatic logic [15:0] byte_swap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    // First word index of the four-word window belonging to port p.
    function automatic logic [5:0] port_base(input int p);
        return CSR_PORT_BASE + 6'(p * CSR_PORT_STRIDE);
    endfunction

endpackage

// File: rtl/ethpipe_csr_intr.sv
// Per-port interrupt pending/mask bank with write-1-to-clear and registered summary.
module ethpipe_csr_intr
    import ethpipe_csr_pkg::*;
#(
    parameter int NPORT = 2
) (
    input  logic             clk_125,
    input  logic             sys_rst,
    input  logic [NPORT-1:0] port_intr,
    input  logic             pend_clr_we,
    input  logic [NPORT-1:0] pend_clr,
    input  logic             mask_we,
    input  logic [NPORT-1:0] mask_wdata,
    output logic [NPORT-1:0] pending,
    output logic [NPORT-1:0] mask,
    output logic             sys_intr
);

    // Pending bits: a new event overrides a clear landing in the same cycle.
    // NOTE: sequential state uses <= so every register samples pre-edge values; sys_intr below therefore sees last cycle's pending.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            pending  <= '0;
            mask     <= '1;
            sys_intr <= 1'b0;
        end else begin
            pending  <= (pending & ~(pend_clr_we ? pend_clr : '0)) | port_intr;
            if (mask_we) mask <= mask_wdata;
            sys_intr <= |(pending & mask);
        end
    end

endmodule

// File: rtl/ethpipe_csr.sv
// BAR0 register bank: global counter, DMA length, per-port DMA addresses/enables, interrupts.
module ethpipe_csr
    import ethpipe_csr_pkg::*;
#(
    parameter int          NPORT           = 2,
    parameter logic [31:0] LEN_RST         = 32'h0001_0000,
    parameter logic [31:0] ADDR_RST_BASE   = 32'h1000_0000,
    parameter logic [31:0] ADDR_RST_STRIDE = 32'h0010_0000
) (
    input  logic                 clk_125,
    input  logic                 sys_rst,
    input  logic [6:0]           slv_bar_i,
    input  logic                 slv_ce_i,
    input  logic                 slv_we_i,
    input  logic [19:1]          slv_adr_i,
    input  logic [15:0]          slv_dat_i,
    input  logic [1:0]           slv_sel_i,
    output logic [15:0]          slv_dat_o,
    output logic [63:0]          global_counter,
    input  logic [NPORT-1:0]     port_intr,
    output logic [19:0]          dma_length,
    output logic [30*NPORT-1:0]  dma_addr_start,
    input  logic [30*NPORT-1:0]  dma_addr_cur,
    output logic [NPORT-1:0]     dma_enable,
    output logic                 sys_intr
);

    logic [5:0]       idx;
    logic             bar_rd;
    logic             rd_en;
    logic             wr_en;
    logic [15:0]      rd_view;
    logic [15:0]      wmask;
    logic [15:0]      wdata_m;
    logic [15:0]      wr_val;
    logic [NPORT-1:0] intr_pending;
    logic [NPORT-1:0] intr_mask;
    // Word 0 of the counter is always returned live, so only words 1-3 need a snapshot.
    logic [63:16]     gcnt_shadow;
    // Only the high word of a current address is ever returned from the snapshot.
    logic [15:0]      cur_shadow [NPORT];
    logic             unused_ok;

    assign idx     = slv_adr_i[6:1];
    assign bar_rd  = slv_ce_i & slv_bar_i[0] & ~slv_we_i;
    assign rd_en   = bar_rd & (slv_adr_i[11:7] == 5'd0);
    assign wr_en   = slv_ce_i & slv_bar_i[0] & slv_we_i & (slv_adr_i[11:7] == 5'd0);
    assign wmask   = {{8{slv_sel_i[0]}}, {8{slv_sel_i[1]}}};
    assign wdata_m = byte_swap(slv_dat_i) & wmask;
    // Writes merge the enabled bytes into the register's current view.
    assign wr_val  = (rd_view & ~wmask) | wdata_m;
    assign unused_ok = ^{slv_bar_i[6:1], slv_adr_i[19:12]};

    // Register view of the addressed word, in register byte order, zero when unmapped.
    // NOTE: rd_view is defaulted before the case so no path through the block leaves it unassigned (no latch).
    always_comb begin
        rd_view = 16'h0000;
        case (idx)
            CSR_GCNT0:     rd_view = global_counter[15:0];
            CSR_GCNT1:     rd_view = gcnt_shadow[31:16];
            CSR_GCNT2:     rd_view = gcnt_shadow[47:32];
            CSR_GCNT3:     rd_view = gcnt_shadow[63:48];
            CSR_INTR_PEND: rd_view = 16'(intr_pending);
            CSR_INTR_MASK: rd_view = 16'(intr_mask);
            CSR_DMA_LEN0:  rd_view = {dma_length[13:0], 2'b00};
            CSR_DMA_LEN1:  rd_view = {10'd0, dma_length[19:14]};
            CSR_DMA_EN:    rd_view = 16'(dma_enable);
            default:       ;
        endcase
        for (int p = 0; p < NPORT; p++) begin
            if ((idx & 6'h3C) == port_base(p)) begin
                case (idx[1:0])
                    2'd0:    rd_view = {dma_addr_start[p*30 +: 14], 2'b00};
                    2'd1:    rd_view = dma_addr_start[p*30+14 +: 16];
                    2'd2:    rd_view = {dma_addr_cur[p*30 +: 14], 2'b00};
                    default: rd_view = cur_shadow[p];
                endcase
            end
        end
    end

    // Counter, read data, snapshots and writable DMA registers.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            global_counter <= 64'd0;
            gcnt_shadow    <= '0;
            slv_dat_o      <= 16'h0000;
            dma_length     <= LEN_RST[21:2];
            dma_enable     <= '0;
            for (int p = 0; p < NPORT; p++) begin
                dma_addr_start[p*30 +: 30] <= 30'((ADDR_RST_BASE + ADDR_RST_STRIDE * 32'(p)) >> 2);
                cur_shadow[p]              <= 16'h0000;
            end
        end else begin
            global_counter <= global_counter + 64'd1;
            if (bar_rd) slv_dat_o <= rd_en ? byte_swap(rd_view) : 16'h0000;
            if (rd_en && idx == CSR_GCNT0) gcnt_shadow <= global_counter[63:16];
            if (wr_en) begin
                case (idx)
                    CSR_DMA_LEN0: dma_length[13:0]  <= wr_val[15:2];
                    CSR_DMA_LEN1: dma_length[19:14] <= wr_val[5:0];
                    CSR_DMA_EN:   dma_enable        <= wr_val[NPORT-1:0];
                    default:      ;
                endcase
            end
            for (int p = 0; p < NPORT; p++) begin
                if ((idx & 6'h3C) == port_base(p)) begin
                    if (wr_en && idx[1:0] == 2'd0) dma_addr_start[p*30 +: 14]    <= wr_val[15:2];
                    if (wr_en && idx[1:0] == 2'd1) dma_addr_start[p*30+14 +: 16] <= wr_val;
                    if (rd_en && idx[1:0] == 2'd2) cur_shadow[p] <= dma_addr_cur[p*30+14 +: 16];
                end
            end
        end
    end

    ethpipe_csr_intr #(.NPORT(NPORT)) u_intr (
        .clk_125     (clk_125),
        .sys_rst     (sys_rst),
        .port_intr   (port_intr),
        .pend_clr_we (wr_en && idx == CSR_INTR_PEND),
        .pend_clr    (wdata_m[NPORT-1:0]),
        .mask_we     (wr_en && idx == CSR_INTR_MASK),
        .mask_wdata  (wr_val[NPORT-1:0]),
        .pending     (intr_pending),
        .mask        (intr_mask),
        .sys_intr    (sys_intr)
    );

endmodule
